uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter START_TIMEOUT, default 15, max cycles from o_Tx_DV to observed i_Tx_Active.
REQ-003 Parameter HOLD_TIMEOUT, default 1023, max idle cycles a granted requester may hold the line mid-packet.
REQ-004 One clock; reset is synchronous and active-high. Ports are i_Clock and i_Reset.
REQ-005 i_Clock  in  1  sole clock, all logic on rising edge.
REQ-006 i_Reset  in  1  synchronous active-high reset.
REQ-007 i_Req_Valid  in  NUM_REQ  requester k has a byte pending.
REQ-008 i_Req_Last  in  NUM_REQ  byte of requester k is last of its packet.
REQ-009 i_Req_Byte  in  NUM_REQ*8  packed bytes, requester k at [8k+7:8k].
REQ-010 o_Req_Ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester k captured.
REQ-011 o_Grant  out  NUM_REQ  one-hot current packet owner, 0 when none.
REQ-012 o_Tx_DV  out  1  one-cycle start pulse to transmitter.
REQ-013 o_Tx_Byte  out  8  byte to transmitter, stable from o_Tx_DV until next capture.
REQ-014 i_Tx_Active  in  1  transmitter active flag.
REQ-015 i_Tx_Done  in  1  transmitter done flag (high for two cycles at frame end).
REQ-016 o_Busy  out  1  high when state is not IDLE.
REQ-017 o_Error  out  1  one-cycle pulse on start or hold timeout.

Function
REQ-018 States: IDLE, WAIT_ACTIVE, WAIT_DONE, WAIT_IDLE, HOLD; all outputs registered.
REQ-019 IDLE: issue only when i_Tx_Active=0 and i_Tx_Done=0; otherwise stay IDLE.
REQ-020 IDLE arbitration: winner w = first k with i_Req_Valid[k]=1 searching from round-robin pointer P upward, wrapping modulo NUM_REQ.
REQ-021 On win, same edge: o_Grant=onehot(w), o_Tx_Byte=byte w, o_Req_Ack[w]=1, o_Tx_DV=1, last-flag latched from i_Req_Last[w], state->WAIT_ACTIVE; latency valid-to-DV = 1 cycle.
REQ-022 o_Tx_DV and o_Req_Ack deassert the following cycle; requester holds valid/byte/last until it sees ack, may change them on the next cycle.
REQ-023 WAIT_ACTIVE: i_Tx_Active=1 -> WAIT_DONE; after START_TIMEOUT cycles without it -> o_Error pulse, grant cleared, P=w+1 mod NUM_REQ, state IDLE.
REQ-024 WAIT_DONE: i_Tx_Done=1 -> WAIT_IDLE.
REQ-025 WAIT_IDLE: when i_Tx_Done=0 and i_Tx_Active=0 -> IDLE if latched last=1 (grant cleared, P=g+1 mod NUM_REQ), else HOLD.
REQ-026 HOLD: grant kept; only i_Req_Valid[g] considered; when valid, act as REQ-021 for g (no re-arbitration), other requesters ignored.
REQ-027 HOLD counter counts cycles with i_Req_Valid[g]=0; reaching HOLD_TIMEOUT -> o_Error pulse, grant cleared, P=g+1 mod NUM_REQ, state IDLE.
REQ-028 Timeout counters reset to 0 on every state entry.
REQ-029 Packets from different requesters never interleave bytes on o_Tx_Byte.
REQ-030 Valid changes on non-granted requesters during a packet have no effect and produce no ack.

Reset
REQ-031 i_Reset=1 at an edge: state IDLE, P=0, counters 0, o_Grant=0, o_Req_Ack=0, o_Tx_DV=0, o_Tx_Byte=0x00, o_Busy=0, o_Error=0.
REQ-032 Reset mid-frame does not reset the transmitter; after reset the block issues nothing until REQ-019 holds.
REQ-033 Reset has priority over all other events in the same cycle.

Verification (transmitter model CLKS_PER_BIT=6)
REQ-034 Single: req0 valid, byte 0xA5, last=1 -> DV one cycle later, o_Tx_Byte=0xA5, ack[0] pulse, grant 0001 through frame, IDLE after done falls, P=1.
REQ-035 Contention: req0..3 valid simultaneously, last=1, P=0 -> grant order 0,1,2,3; next round from P=0 repeats order.
REQ-036 Packet lock: req1 sends 0x11,0x22(last) while req2 valid -> 0x11,0x22 serialised on line before any req2 byte; req2 acked only after.
REQ-037 Hold timeout: req3 sends 0x33 last=0 then drops valid -> o_Error pulse 1023 cycles after HOLD entry, grant cleared, P=0.
REQ-038 Start timeout: transmitter model held idle (never active) -> o_Error pulse 15 cycles after DV, state IDLE.
REQ-039 Reset mid-frame: assert i_Reset during data bits -> outputs zero next cycle; pending req0 reissued only after transmitter done and active both low.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources. A packet owner is
// chosen round-robin and keeps the transmitter until its last byte has gone
// out, so bytes of different packets never interleave. Start and hold
// watchdogs release a stuck owner with a one-cycle error pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 15,
  parameter int HOLD_TIMEOUT  = 1023
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  input  logic [NUM_REQ*8-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Error
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (START_TIMEOUT > HOLD_TIMEOUT) ? START_TIMEOUT : HOLD_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ACTIVE,
    ST_WAIT_DONE,
    ST_WAIT_IDLE,
    ST_HOLD
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic               dv_reg, dv_next;
  logic [7:0]         byte_reg, byte_next;
  logic               last_reg, last_next;
  logic               error_reg, error_next;
  logic               busy_reg;

  logic [7:0]         req_byte [NUM_REQ];
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               issue;
  logic [IDX_W-1:0]   issue_idx;
  logic               release_grant;

  // Split the packed byte bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = i_Req_Byte[8*gi +: 8];
    end
  endgenerate

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(ptr_reg) + i) % NUM_REQ);
      if (!win_found && i_Req_Valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: packet ownership, transmitter handshake and watchdogs.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    idx_next      = idx_reg;
    cnt_next      = cnt_reg;
    grant_next    = grant_reg;
    byte_next     = byte_reg;
    last_next     = last_reg;
    ack_next      = '0;
    dv_next       = 1'b0;
    error_next    = 1'b0;
    issue         = 1'b0;
    issue_idx     = idx_reg;
    release_grant = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!i_Tx_Active && !i_Tx_Done && win_found) begin
          issue     = 1'b1;
          issue_idx = win_idx;
        end
      end
      ST_WAIT_ACTIVE: begin
        if (i_Tx_Active) begin
          state_next = ST_WAIT_DONE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(START_TIMEOUT - 1)) begin
          error_next    = 1'b1;
          release_grant = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          state_next = ST_WAIT_IDLE;
          cnt_next   = '0;
        end
      end
      ST_WAIT_IDLE: begin
        if (!i_Tx_Done && !i_Tx_Active) begin
          if (last_reg) begin
            release_grant = 1'b1;
          end else begin
            state_next = ST_HOLD;
            cnt_next   = '0;
          end
        end
      end
      ST_HOLD: begin
        // Only the owner may continue; everyone else waits for the release.
        if (i_Req_Valid[idx_reg]) begin
          issue     = 1'b1;
          issue_idx = idx_reg;
        end else if (cnt_reg == CNT_W'(HOLD_TIMEOUT - 1)) begin
          error_next    = 1'b1;
          release_grant = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (issue) begin
      state_next = ST_WAIT_ACTIVE;
      cnt_next   = '0;
      idx_next   = issue_idx;
      grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << issue_idx;
      ack_next   = {{(NUM_REQ-1){1'b0}}, 1'b1} << issue_idx;
      dv_next    = 1'b1;
      byte_next  = req_byte[issue_idx];
      last_next  = i_Req_Last[issue_idx];
    end

    // Releasing always hands priority to the requester after the owner.
    if (release_grant) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      grant_next = '0;
      ptr_next   = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  // State and output registers; reset wins over everything else.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      ack_reg   <= '0;
      dv_reg    <= 1'b0;
      byte_reg  <= 8'h00;
      last_reg  <= 1'b0;
      error_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      ack_reg   <= ack_next;
      dv_reg    <= dv_next;
      byte_reg  <= byte_next;
      last_reg  <= last_next;
      error_reg <= error_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  assign o_Req_Ack = ack_reg;
  assign o_Grant   = grant_reg;
  assign o_Tx_DV   = dv_reg;
  assign o_Tx_Byte = byte_reg;
  assign o_Busy    = busy_reg;
  assign o_Error   = error_reg;

endmodule
